// File: rtl/spatz_issue_ctrl_pkg.sv
// Shared types for the Spatz issue controller: request format, execution-unit
// encoding, issue FSM states and default sizing.
package spatz_issue_ctrl_pkg;

    localparam int DefaultNrVregs        = 32;
    localparam int DefaultMaxOutstanding = 4;
    localparam int NrUnits               = 2;

    typedef enum logic [1:0] {
        EX_VFU  = 2'd0,
        EX_VLSU = 2'd1
    } ex_unit_e;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        STALL    = 2'd1,
        DISPATCH = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [7:0]  op;
        ex_unit_e    ex_unit;
        logic [15:0] vl;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic        use_vd;
        logic        use_vs1;
        logic        use_vs2;
        logic        vd_is_src;
    } spatz_req_t;

    // Only VFU and VLSU exist; the remaining encodings are dropped on entry.
    function automatic logic unit_is_valid(input ex_unit_e unit);
        return (unit == EX_VFU) || (unit == EX_VLSU);
    endfunction

    // Index of a unit in per-unit arrays (VFU=0, VLSU=1).
    function automatic logic unit_idx(input ex_unit_e unit);
        return unit == EX_VLSU;
    endfunction

endpackage

// File: rtl/spatz_issue_ctrl_if.sv
// Valid/ready request channel carrying one spatz_req_t.
interface spatz_issue_ctrl_if;
    import spatz_issue_ctrl_pkg::*;

    spatz_req_t req;
    logic       valid;
    logic       ready;

    modport master (output req, output valid, input ready);
    modport slave  (input req, input valid, output ready);
endinterface

// File: rtl/spatz_issue_ctrl_scoreboard.sv
// Per-vreg pending-write scoreboard: one set port (dispatch), two clear ports
// (unit completion) and three combinational lookups of the registered state.
// Lookups never see a same-cycle clear.
module spatz_issue_ctrl_scoreboard #(
    parameter int NrVregs = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       set_i,
    input  logic [4:0] set_idx_i,
    input  logic       clr_a_i,
    input  logic [4:0] clr_a_idx_i,
    input  logic       clr_b_i,
    input  logic [4:0] clr_b_idx_i,
    input  logic [4:0] vs1_idx_i,
    input  logic [4:0] vs2_idx_i,
    input  logic [4:0] vd_idx_i,
    output logic       vs1_busy_o,
    output logic       vs2_busy_o,
    output logic       vd_busy_o
);

    logic [NrVregs-1:0] busy_q;
    logic [NrVregs-1:0] busy_d;

    assign vs1_busy_o = busy_q[vs1_idx_i];
    assign vs2_busy_o = busy_q[vs2_idx_i];
    assign vd_busy_o  = busy_q[vd_idx_i];

    // Apply the dispatch set and both completion clears to the busy vector.
    always_comb begin
        busy_d = busy_q;
        if (set_i)   busy_d[set_idx_i]   = 1'b1;
        if (clr_a_i) busy_d[clr_a_idx_i] = 1'b0;
        if (clr_b_i) busy_d[clr_b_idx_i] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

`ifndef SYNTHESIS
    // A register cannot be dispatched while still pending, so set and clear
    // of the same bit in one cycle indicates a broken hazard check upstream.
    a_set_clr_conflict: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(set_i && ((clr_a_i && clr_a_idx_i == set_idx_i) ||
                    (clr_b_i && clr_b_idx_i == set_idx_i))));
`endif

endmodule

// File: rtl/spatz_issue_ctrl.sv
// Issue controller in front of the Spatz VFU and VLSU. Holds one request,
// stalls it on RAW/WAW hazards or a full unit, and dispatches it from the
// buffer register to the selected unit.
module spatz_issue_ctrl
    import spatz_issue_ctrl_pkg::*;
#(
    parameter int NrVregs        = spatz_issue_ctrl_pkg::DefaultNrVregs,
    parameter int MaxOutstanding = spatz_issue_ctrl_pkg::DefaultMaxOutstanding
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    spatz_issue_ctrl_if.slave         spatz_req,
    spatz_issue_ctrl_if.master        vfu_req,
    input  logic                      vfu_done_i,
    input  logic [4:0]                vfu_done_vd_i,
    input  logic                      vfu_done_we_i,
    spatz_issue_ctrl_if.master        vlsu_req,
    input  logic                      vlsu_done_i,
    input  logic [4:0]                vlsu_done_vd_i,
    input  logic                      vlsu_done_we_i,
    output logic                      busy_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);

    issue_state_e     state_q, state_d;
    spatz_req_t       buf_q;
    logic [CntW-1:0]  out_q [NrUnits];

    logic             tgt_ready, disp, fire, accept, latch;
    logic             pend_set, pend_cnt, hazard;
    logic [4:0]       rd_vs1, rd_vs2, rd_vd;
    logic             rd_use_vs1, rd_use_vs2, rd_use_vd;
    ex_unit_e         rd_unit;
    logic             sb_vs1, sb_vs2, sb_vd;
    logic [CntW:0]    rd_cnt;
    logic [NrUnits-1:0] inc, dec;

    assign tgt_ready = (buf_q.ex_unit == EX_VLSU) ? vlsu_req.ready : vfu_req.ready;
    assign fire      = disp & tgt_ready;

    assign vfu_req.req    = buf_q;
    assign vlsu_req.req   = buf_q;
    assign vfu_req.valid  = disp && (buf_q.ex_unit == EX_VFU);
    assign vlsu_req.valid = disp && (buf_q.ex_unit == EX_VLSU);

    assign inc[0] = fire && (buf_q.ex_unit == EX_VFU);
    assign inc[1] = fire && (buf_q.ex_unit == EX_VLSU);
    assign dec[0] = vfu_done_i;
    assign dec[1] = vlsu_done_i;

    spatz_issue_ctrl_scoreboard #(
        .NrVregs (NrVregs)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .set_i       (fire && buf_q.use_vd),
        .set_idx_i   (buf_q.vd),
        .clr_a_i     (vfu_done_i && vfu_done_we_i),
        .clr_a_idx_i (vfu_done_vd_i),
        .clr_b_i     (vlsu_done_i && vlsu_done_we_i),
        .clr_b_idx_i (vlsu_done_vd_i),
        .vs1_idx_i   (rd_vs1),
        .vs2_idx_i   (rd_vs2),
        .vd_idx_i    (rd_vd),
        .vs1_busy_o  (sb_vs1),
        .vs2_busy_o  (sb_vs2),
        .vd_busy_o   (sb_vd)
    );

    // Hazard check: the stalled buffer in STALL, otherwise the incoming
    // request. A request accepted while the buffer dispatches must also see
    // the busy bit and counter increment that dispatch is about to commit.
    always_comb begin
        if (state_q == STALL) begin
            rd_vs1     = buf_q.vs1;
            rd_vs2     = buf_q.vs2;
            rd_vd      = buf_q.vd;
            rd_use_vs1 = buf_q.use_vs1;
            rd_use_vs2 = buf_q.use_vs2;
            rd_use_vd  = buf_q.use_vd | buf_q.vd_is_src;
            rd_unit    = buf_q.ex_unit;
        end else begin
            rd_vs1     = spatz_req.req.vs1;
            rd_vs2     = spatz_req.req.vs2;
            rd_vd      = spatz_req.req.vd;
            rd_use_vs1 = spatz_req.req.use_vs1;
            rd_use_vs2 = spatz_req.req.use_vs2;
            rd_use_vd  = spatz_req.req.use_vd | spatz_req.req.vd_is_src;
            rd_unit    = spatz_req.req.ex_unit;
        end
        pend_set = (state_q == DISPATCH) && tgt_ready && buf_q.use_vd;
        pend_cnt = (state_q == DISPATCH) && tgt_ready && (buf_q.ex_unit == rd_unit);
        rd_cnt   = {1'b0, out_q[unit_idx(rd_unit)]} + {{CntW{1'b0}}, pend_cnt};
        hazard   = ((sb_vs2 | (pend_set && buf_q.vd == rd_vs2)) && rd_use_vs2) |
                   ((sb_vs1 | (pend_set && buf_q.vd == rd_vs1)) && rd_use_vs1) |
                   ((sb_vd  | (pend_set && buf_q.vd == rd_vd))  && rd_use_vd)  |
                   (rd_cnt >= (CntW+1)'(MaxOutstanding));
    end

    // Issue FSM: next state, dispatch strobe and upstream ready. vl==0 and
    // unknown-unit requests are consumed without touching the buffer.
    always_comb begin
        state_d         = state_q;
        spatz_req.ready = 1'b0;
        disp            = 1'b0;
        accept          = 1'b0;
        latch           = 1'b0;
        case (state_q)
            EMPTY: begin
                spatz_req.ready = 1'b1;
                accept          = spatz_req.valid;
            end
            STALL: begin
                if (!hazard) begin
                    disp    = 1'b1;
                    state_d = tgt_ready ? EMPTY : DISPATCH;
                end
            end
            DISPATCH: begin
                disp            = 1'b1;
                spatz_req.ready = tgt_ready;
                if (tgt_ready) begin
                    state_d = EMPTY;
                    accept  = spatz_req.valid;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (accept && (spatz_req.req.vl != '0) && unit_is_valid(spatz_req.req.ex_unit)) begin
            latch   = 1'b1;
            state_d = hazard ? STALL : DISPATCH;
        end
    end

    // State and request buffer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch) buf_q <= spatz_req.req;
        end
    end

    // Per-unit in-flight counters; dispatch and completion together cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int u = 0; u < NrUnits; u++) out_q[u] <= '0;
        end else begin
            for (int u = 0; u < NrUnits; u++) begin
                if (inc[u] && !dec[u])      out_q[u] <= out_q[u] + CntW'(1);
                else if (dec[u] && !inc[u]) out_q[u] <= out_q[u] - CntW'(1);
            end
        end
    end

    // Busy while a request is held or any unit has work in flight.
    always_comb begin
        busy_o = (state_q != EMPTY);
        for (int u = 0; u < NrUnits; u++) busy_o = busy_o | (|out_q[u]);
    end

`ifndef SYNTHESIS
    a_invalid_unit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(accept && (spatz_req.req.vl != '0) && !unit_is_valid(spatz_req.req.ex_unit)));
    a_vfu_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dec[0] && !inc[0] && (out_q[0] == '0)));
    a_vlsu_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dec[1] && !inc[1] && (out_q[1] == '0)));
`endif

endmodule

// File: tb/tb_spatz_issue_ctrl.sv
// Directed bench for spatz_issue_ctrl: stimulus pushes expected dispatches
// (vd, op, cycle) per unit, an independent monitor pops them on each unit
// handshake.
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

module tb_spatz_issue_ctrl;
    import spatz_issue_ctrl_pkg::*;

    typedef struct {
        logic [4:0] vd;
        logic [7:0] op;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vfu_done, vfu_done_we, vlsu_done, vlsu_done_we;
    logic [4:0] vfu_done_vd, vlsu_done_vd;
    logic       busy;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q_vfu[$];
    exp_t q_vlsu[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spatz_issue_ctrl_if req_if ();
    spatz_issue_ctrl_if vfu_if ();
    spatz_issue_ctrl_if vlsu_if ();

    spatz_issue_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .spatz_req      (req_if),
        .vfu_req        (vfu_if),
        .vfu_done_i     (vfu_done),
        .vfu_done_vd_i  (vfu_done_vd),
        .vfu_done_we_i  (vfu_done_we),
        .vlsu_req       (vlsu_if),
        .vlsu_done_i    (vlsu_done),
        .vlsu_done_vd_i (vlsu_done_vd),
        .vlsu_done_we_i (vlsu_done_we),
        .busy_o         (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic spatz_req_t mk(input ex_unit_e u, input logic [7:0] op,
                                      input logic [4:0] vd, input logic [4:0] vs1,
                                      input logic [4:0] vs2, input logic use_vd,
                                      input logic use_vs1, input logic use_vs2,
                                      input logic [15:0] vl);
        spatz_req_t r;
        r         = '0;
        r.op      = op;
        r.ex_unit = u;
        r.vl      = vl;
        r.vd      = vd;
        r.vs1     = vs1;
        r.vs2     = vs2;
        r.use_vd  = use_vd;
        r.use_vs1 = use_vs1;
        r.use_vs2 = use_vs2;
        return r;
    endfunction

    // Present one request for one cycle; it must be accepted in that cycle.
    // When disp is set, the dispatch is expected disp_off cycles later.
    task automatic issue(input spatz_req_t r, input int disp_off, input bit disp);
        exp_t e;
        if (disp) begin
            e.vd  = r.vd;
            e.op  = r.op;
            e.cyc = cyc + disp_off;
            if (r.ex_unit == EX_VLSU) q_vlsu.push_back(e);
            else                      q_vfu.push_back(e);
        end
        req_if.req   = r;
        req_if.valid = 1'b1;
        @(negedge clk);
        `CHK("accept", req_if.ready, 1'b1);
        tick();
        req_if.valid = 1'b0;
        req_if.req   = '0;
    endtask

    task automatic done_pulse(input bit to_vlsu, input logic [4:0] vd);
        if (to_vlsu) begin
            vlsu_done = 1'b1; vlsu_done_vd = vd; vlsu_done_we = 1'b1;
        end else begin
            vfu_done = 1'b1; vfu_done_vd = vd; vfu_done_we = 1'b1;
        end
        tick();
        vfu_done = 1'b0; vfu_done_we = 1'b0; vlsu_done = 1'b0; vlsu_done_we = 1'b0;
    endtask

    // Monitor: every unit handshake must match the oldest expected dispatch.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (vfu_if.valid && vfu_if.ready) begin
            if (q_vfu.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL vfu_unexpected: dispatch vd=%0d at cycle %0d, none expected",
                         vfu_if.req.vd, cyc);
            end else begin
                e = q_vfu.pop_front();
                `CHK("vfu_vd", vfu_if.req.vd, e.vd);
                `CHK("vfu_op", vfu_if.req.op, e.op);
                `CHK("vfu_cycle", cyc, e.cyc);
            end
        end
        if (vlsu_if.valid && vlsu_if.ready) begin
            if (q_vlsu.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL vlsu_unexpected: dispatch vd=%0d at cycle %0d, none expected",
                         vlsu_if.req.vd, cyc);
            end else begin
                e = q_vlsu.pop_front();
                `CHK("vlsu_vd", vlsu_if.req.vd, e.vd);
                `CHK("vlsu_op", vlsu_if.req.op, e.op);
                `CHK("vlsu_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst_n         = 1'b1;
        req_if.valid  = 1'b0;
        req_if.req    = '0;
        vfu_if.ready  = 1'b1;
        vlsu_if.ready = 1'b1;
        vfu_done = 1'b0; vfu_done_vd = '0; vfu_done_we = 1'b0;
        vlsu_done = 1'b0; vlsu_done_vd = '0; vlsu_done_we = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        `CHK("rst_ready", req_if.ready, 1'b1);
        `CHK("rst_vfu_valid", vfu_if.valid, 1'b0);
        `CHK("rst_vlsu_valid", vlsu_if.valid, 1'b0);
        `CHK("rst_busy", busy, 1'b0);
        `CHK("rst_vfu_req", vfu_if.req, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // vadd v3,v1,v2 into an idle controller
        issue(mk(EX_VFU, 8'h01, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 16'd16), 1, 1'b1);
        @(negedge clk);
        `CHK("t1_busy_dispatch", busy, 1'b1);
        tick();
        `CHK("t1_sb3_set", dut.u_sb.busy_q[3], 1'b1);
        done_pulse(1'b0, 5'd3);
        `CHK("t1_sb3_clear", dut.u_sb.busy_q[3], 1'b0);
        `CHK("t1_idle", busy, 1'b0);

        // vl==0 is retired without dispatch
        issue(mk(EX_VFU, 8'h01, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 16'd0), 0, 1'b0);
        @(negedge clk);
        `CHK("vl0_busy", busy, 1'b0);
        `CHK("vl0_sb9", dut.u_sb.busy_q[9], 1'b0);
        tick();

        // vle v4 then vadd v5,v4,v1: RAW stall until the load completes
        issue(mk(EX_VLSU, 8'h10, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'd8), 1, 1'b1);
        issue(mk(EX_VFU, 8'h01, 5'd5, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 16'd8), 4, 1'b1);
        tick();
        `CHK("t2_stall_a", vfu_if.valid, 1'b0);
        `CHK("t2_stall_ready", req_if.ready, 1'b0);
        tick();
        `CHK("t2_stall_b", vfu_if.valid, 1'b0);
        done_pulse(1'b1, 5'd4);
        tick();
        done_pulse(1'b0, 5'd5);
        `CHK("t2_idle", busy, 1'b0);

        // vadd v6 then vmul v6: WAW hold until the first write completes
        issue(mk(EX_VFU, 8'h01, 5'd6, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 16'd8), 1, 1'b1);
        issue(mk(EX_VFU, 8'h02, 5'd6, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 16'd8), 3, 1'b1);
        tick();
        `CHK("t3_waw_hold", vfu_if.valid, 1'b0);
        done_pulse(1'b0, 5'd6);
        tick();
        done_pulse(1'b0, 5'd6);
        `CHK("t3_idle", busy, 1'b0);

        // five independent VFU requests: the fifth waits for a free slot
        for (int i = 0; i < 4; i++)
            issue(mk(EX_VFU, 8'h01, 5'(10 + i), 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'd8), 1, 1'b1);
        issue(mk(EX_VFU, 8'h01, 5'd14, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'd8), 4, 1'b1);
        tick();
        `CHK("t4_fifth_stalled", vfu_if.valid, 1'b0);
        `CHK("t4_out_full", dut.out_q[0], 4);
        tick();
        done_pulse(1'b0, 5'd10);
        tick();
        for (int v = 11; v <= 14; v++) done_pulse(1'b0, 5'(v));
        `CHK("t4_idle", busy, 1'b0);

        // simultaneous completion from both units
        issue(mk(EX_VFU, 8'h01, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'd8), 1, 1'b1);
        issue(mk(EX_VLSU, 8'h10, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 16'd8), 1, 1'b1);
        tick();
        `CHK("t5_sb2_set", dut.u_sb.busy_q[2], 1'b1);
        `CHK("t5_sb7_set", dut.u_sb.busy_q[7], 1'b1);
        `CHK("t5_out_vfu", dut.out_q[0], 1);
        `CHK("t5_out_vlsu", dut.out_q[1], 1);
        vfu_done = 1'b1; vfu_done_vd = 5'd2; vfu_done_we = 1'b1;
        vlsu_done = 1'b1; vlsu_done_vd = 5'd7; vlsu_done_we = 1'b1;
        tick();
        vfu_done = 1'b0; vfu_done_we = 1'b0; vlsu_done = 1'b0; vlsu_done_we = 1'b0;
        `CHK("t5_sb2_clear", dut.u_sb.busy_q[2], 1'b0);
        `CHK("t5_sb7_clear", dut.u_sb.busy_q[7], 1'b0);
        `CHK("t5_out_vfu_zero", dut.out_q[0], 0);
        `CHK("t5_out_vlsu_zero", dut.out_q[1], 0);
        `CHK("t5_idle", busy, 1'b0);

        // asynchronous reset while a RAW-stalled request is held
        issue(mk(EX_VFU, 8'h01, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 16'd8), 1, 1'b1);
        issue(mk(EX_VFU, 8'h01, 5'd8, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 16'd8), 0, 1'b0);
        tick();
        `CHK("t6_sb3_set", dut.u_sb.busy_q[3], 1'b1);
        `CHK("t6_busy", busy, 1'b1);
        `CHK("t6_stall_ready", req_if.ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        `CHK("t6_rst_ready", req_if.ready, 1'b1);
        `CHK("t6_rst_vfu_valid", vfu_if.valid, 1'b0);
        `CHK("t6_rst_vlsu_valid", vlsu_if.valid, 1'b0);
        `CHK("t6_rst_busy", busy, 1'b0);
        `CHK("t6_rst_sb", dut.u_sb.busy_q, 0);
        `CHK("t6_rst_vfu_req", vfu_if.req, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        `CHK("t6_post_busy", busy, 1'b0);

        `CHK("q_vfu_drained", q_vfu.size(), 0);
        `CHK("q_vlsu_drained", q_vlsu.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
